// File: rtl/adc_uart_streamer_if.sv
// Byte stream handshake between the ADC frame streamer and the UART serialiser.
interface adc_uart_streamer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/adc_uart_streamer.sv
// Snapshots enabled ADC channels on decimated sample ticks and streams a framed
// byte sequence (sync, HI/LO per channel, XOR checksum) over a valid/ready link.
module adc_uart_streamer #(
  parameter int         NUM_CH    = 8,
  parameter int         SAMPLE_W  = 12,
  parameter int         DATA_BITS = 8,
  parameter int         DECIM     = 1,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_CH*SAMPLE_W-1:0] i_ch_data,
  input  logic                       i_sample_tick,
  input  logic                       i_enb,
  input  logic [NUM_CH-1:0]          i_ch_mask,
  adc_uart_streamer_if.master        tx_if,
  output logic                       o_busy,
  output logic [7:0]                 o_overrun_cnt
);

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_HI, ST_LO, ST_CSUM} state_t;

  state_t                   r_state, w_nxt_state;
  logic [15:0]              r_dec_cnt, w_nxt_dec;
  logic [NUM_CH-1:0][11:0]  r_shadow, w_nxt_shadow;
  logic [NUM_CH-1:0]        r_shadow_mask, w_nxt_mask;
  logic [3:0]               r_ch_idx, w_nxt_idx;
  logic [7:0]               r_csum, w_nxt_csum;
  logic [DATA_BITS-1:0]     r_tx_data, w_nxt_data;
  logic                     r_tx_valid, w_nxt_valid;
  logic                     r_busy;
  logic [7:0]               r_overrun, w_nxt_ovr;

  logic                     w_qual, w_launch, w_xfer;
  logic [4:0]               w_srch_lo, w_srch;
  logic [11:0]              w_srch_sample, w_cur_sample;

  // Lowest enabled channel at or above lo; bit 4 flags that one was found.
  function automatic logic [4:0] find_next(input logic [NUM_CH-1:0] mask, input logic [4:0] lo);
    logic [4:0] res;
    res = 5'd0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k] && (5'(k) >= lo)) res = {1'b1, 4'(k)};
    end
    return res;
  endfunction

  function automatic logic [11:0] sel_sample(input logic [NUM_CH-1:0][11:0] sh, input logic [3:0] idx);
    logic [11:0] s;
    s = 12'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (4'(k) == idx) s = sh[k];
    end
    return s;
  endfunction

  assign w_qual        = i_sample_tick & i_enb;
  assign w_launch      = w_qual && (r_dec_cnt == 16'(DECIM - 1));
  assign w_xfer        = r_tx_valid & tx_if.tx_ready;
  assign w_srch_lo     = (r_state == ST_SYNC) ? 5'd0 : ({1'b0, r_ch_idx} + 5'd1);
  assign w_srch        = find_next(r_shadow_mask, w_srch_lo);
  assign w_srch_sample = sel_sample(r_shadow, w_srch[3:0]);
  assign w_cur_sample  = sel_sample(r_shadow, r_ch_idx);

  // Decimation counter: counts qualified ticks, held at zero while disabled.
  always_comb begin
    w_nxt_dec = r_dec_cnt;
    if (!i_enb) begin
      w_nxt_dec = 16'd0;
    end else if (w_qual) begin
      w_nxt_dec = w_launch ? 16'd0 : (r_dec_cnt + 16'd1);
    end else begin
      w_nxt_dec = r_dec_cnt;
    end
  end

  // Launches arriving while a frame is in flight are dropped and counted.
  always_comb begin
    w_nxt_ovr = r_overrun;
    if (w_launch && (r_state != ST_IDLE) && (r_overrun != 8'hFF)) begin
      w_nxt_ovr = r_overrun + 8'd1;
    end else begin
      w_nxt_ovr = r_overrun;
    end
  end

  // Frame sequencer: next state plus the next byte to present.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_data   = r_tx_data;
    w_nxt_valid  = r_tx_valid;
    w_nxt_idx    = r_ch_idx;
    w_nxt_csum   = r_csum;
    w_nxt_shadow = r_shadow;
    w_nxt_mask   = r_shadow_mask;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          for (int k = 0; k < NUM_CH; k++) begin
            w_nxt_shadow[k] = 12'(i_ch_data[k*SAMPLE_W +: SAMPLE_W]);
          end
          w_nxt_mask = i_ch_mask;
          w_nxt_csum = 8'd0;
          if (i_ch_mask != '0) begin
            w_nxt_state = ST_SYNC;
            w_nxt_data  = DATA_BITS'(SYNC_BYTE);
            w_nxt_valid = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (w_xfer) begin
          w_nxt_idx   = w_srch[3:0];
          w_nxt_data  = DATA_BITS'({w_srch[3:0], w_srch_sample[11:8]});
          w_nxt_state = ST_HI;
        end else begin
          w_nxt_state = ST_SYNC;
        end
      end
      ST_HI: begin
        if (w_xfer) begin
          w_nxt_csum  = r_csum ^ r_tx_data[7:0];
          w_nxt_data  = DATA_BITS'(w_cur_sample[7:0]);
          w_nxt_state = ST_LO;
        end else begin
          w_nxt_state = ST_HI;
        end
      end
      ST_LO: begin
        if (w_xfer) begin
          w_nxt_csum = r_csum ^ r_tx_data[7:0];
          if (w_srch[4]) begin
            w_nxt_idx   = w_srch[3:0];
            w_nxt_data  = DATA_BITS'({w_srch[3:0], w_srch_sample[11:8]});
            w_nxt_state = ST_HI;
          end else begin
            w_nxt_data  = DATA_BITS'(r_csum ^ r_tx_data[7:0]);
            w_nxt_state = ST_CSUM;
          end
        end else begin
          w_nxt_state = ST_LO;
        end
      end
      ST_CSUM: begin
        if (w_xfer) begin
          w_nxt_valid = 1'b0;
          w_nxt_data  = '0;
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_state = ST_CSUM;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_valid = 1'b0;
        w_nxt_data  = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_dec_cnt     <= 16'd0;
      r_shadow      <= '0;
      r_shadow_mask <= '0;
      r_ch_idx      <= 4'd0;
      r_csum        <= 8'd0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 8'd0;
    end else begin
      r_state       <= w_nxt_state;
      r_dec_cnt     <= w_nxt_dec;
      r_shadow      <= w_nxt_shadow;
      r_shadow_mask <= w_nxt_mask;
      r_ch_idx      <= w_nxt_idx;
      r_csum        <= w_nxt_csum;
      r_tx_data     <= w_nxt_data;
      r_tx_valid    <= w_nxt_valid;
      r_busy        <= (w_nxt_state != ST_IDLE);
      r_overrun     <= w_nxt_ovr;
    end
  end

  assign tx_if.tx_data  = r_tx_data;
  assign tx_if.tx_valid = r_tx_valid;
  assign o_busy         = r_busy;
  assign o_overrun_cnt  = r_overrun;

endmodule

// File: tb/tb_adc_uart_streamer.sv
// Randomised bench for adc_uart_streamer against a frame-level reference model.
module tb_adc_uart_streamer;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] ch_data;
  logic        tick, enb;
  logic [7:0]  mask;
  logic        busy, busy4;
  logic [7:0]  ovr, ovr4;
  int          n_checks = 0;
  int          n_pass = 0;
  int          dcnt;
  int          vcyc;
  logic        found, bad;
  byte_q_t     rx_q, rx4_q, exp_q, exp4_q, lit;

  always #5 clk = ~clk;

  adc_uart_streamer_if #(.DATA_BITS(8)) tx_if ();
  adc_uart_streamer_if #(.DATA_BITS(8)) tx4_if ();

  adc_uart_streamer #(.NUM_CH(8), .SAMPLE_W(12), .DATA_BITS(8), .DECIM(1), .SYNC_BYTE(8'hA5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_data(ch_data), .i_sample_tick(tick), .i_enb(enb),
    .i_ch_mask(mask), .tx_if(tx_if), .o_busy(busy), .o_overrun_cnt(ovr));

  adc_uart_streamer #(.NUM_CH(8), .SAMPLE_W(12), .DATA_BITS(8), .DECIM(4), .SYNC_BYTE(8'hA5)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_data(ch_data), .i_sample_tick(tick), .i_enb(enb),
    .i_ch_mask(mask), .tx_if(tx4_if), .o_busy(busy4), .o_overrun_cnt(ovr4));

  // Record every accepted byte (valid && ready seen mid-cycle).
  always @(negedge clk) begin
    if (tx_if.tx_valid && tx_if.tx_ready) rx_q.push_back(tx_if.tx_data);
    if (tx4_if.tx_valid && tx4_if.tx_ready) rx4_q.push_back(tx4_if.tx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference frame: sync, {idx,hi nibble}/low byte per enabled channel, XOR of those.
  function automatic byte_q_t model_frame(input logic [95:0] d, input logic [7:0] m);
    byte_q_t    q;
    logic [7:0] cs, hi, lo;
    logic [11:0] s;
    q = {};
    if (m == 8'h00) return q;
    q.push_back(8'hA5);
    cs = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        s  = d[k*12 +: 12];
        hi = {4'(k), s[11:8]};
        lo = s[7:0];
        q.push_back(hi);
        q.push_back(lo);
        cs = cs ^ hi ^ lo;
      end
    end
    q.push_back(cs);
    return q;
  endfunction

  task automatic compare_q(input string tag, input byte_q_t got, input byte_q_t want);
    check({tag, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD, {24'd0, want[i]});
  endtask

  task automatic pulse_tick(input logic en);
    @(posedge clk); #1;
    enb = en; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; enb = 1'b1;
  endtask

  task automatic wait_idle(input string tag, output int vc);
    logic done;
    vc = 0; done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (tx_if.tx_valid) vc++;
      if (!busy) done = 1'b1;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; tick = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx_q = {}; rx4_q = {};
  endtask

  task automatic rand_data();
    for (int k = 0; k < 3; k++) ch_data[k*32 +: 32] = $urandom;
  endtask

  // Decimation stimulus with the spec-level tick counter kept here.
  task automatic dtick(input logic en);
    rand_data();
    mask = 8'($urandom_range(1, 255));
    if (en) begin
      dcnt++;
      if (dcnt == 4) begin
        dcnt = 0;
        exp4_q = {exp4_q, model_frame(ch_data, mask)};
      end
    end else begin
      dcnt = 0;
    end
    pulse_tick(en);
    repeat (25) @(posedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick = 1'b0; enb = 1'b1; mask = 8'h00; ch_data = '0;
    tx_if.tx_ready = 1'b1; tx4_if.tx_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_valid", tx_if.tx_valid, 1'b0);
    check("rst_data", tx_if.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ovr", ovr, 8'h00);
    rst_n = 1'b1;

    // Basic frame
    rand_data();
    ch_data[0 +: 12] = 12'h123; ch_data[24 +: 12] = 12'hABC; mask = 8'h05;
    lit = {8'hA5, 8'h01, 8'h23, 8'h2A, 8'hBC, 8'hB4};
    rx_q = {};
    pulse_tick(1'b1);
    wait_idle("basic", vcyc);
    check("basic_valid_run", vcyc, 6);
    compare_q("basic", rx_q, lit);
    compare_q("basic_model", model_frame(ch_data, mask), lit);

    // Backpressure with mid-frame data change
    rx_q = {};
    pulse_tick(1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (tx_if.tx_valid && tx_if.tx_data == 8'h23) found = 1'b1;
    end
    check("bp_found_23", found, 1'b1);
    tx_if.tx_ready = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) ch_data[0 +: 12] = 12'h456;
      if (!tx_if.tx_valid || tx_if.tx_data != 8'h23) bad = 1'b1;
    end
    check("bp_hold_stable", bad, 1'b0);
    @(posedge clk); #1;
    tx_if.tx_ready = 1'b1;
    wait_idle("bp", vcyc);
    compare_q("bp", rx_q, lit);

    // Overrun: one extra tick, then saturation
    rand_data(); mask = 8'h0F;
    exp_q = model_frame(ch_data, mask);
    rx_q = {};
    pulse_tick(1'b1);
    repeat (2) @(posedge clk);
    pulse_tick(1'b1);
    wait_idle("ovr1", vcyc);
    check("ovr_one", ovr, 8'd1);
    compare_q("ovr_frame", rx_q, exp_q);
    tx_if.tx_ready = 1'b0;
    pulse_tick(1'b1);
    for (int i = 0; i < 300; i++) pulse_tick(1'b1);
    check("ovr_sat", ovr, 8'd255);
    tx_if.tx_ready = 1'b1;
    wait_idle("ovr_drain", vcyc);

    // Decimation on the DECIM=4 instance
    do_reset();
    dcnt = 0; exp4_q = {};
    dtick(1'b0);
    repeat (3) dtick(1'b1);
    check("dec_none_before4", rx4_q.size(), 0);
    dtick(1'b1);
    dtick(1'b0);
    repeat (4) dtick(1'b1);
    repeat (2) dtick(1'b1);
    dtick(1'b0);
    repeat (3) dtick(1'b1);
    check("dec_frames_so_far", rx4_q.size(), exp4_q.size());
    dtick(1'b1);
    compare_q("dec", rx4_q, exp4_q);
    check("dec_ovr1", ovr, 8'd0);

    // Empty mask, then single high channel
    do_reset();
    mask = 8'h00;
    pulse_tick(1'b1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_if.tx_valid || busy) bad = 1'b1;
    end
    check("empty_no_activity", bad, 1'b0);
    check("empty_ovr", ovr, 8'd0);
    rand_data(); ch_data[84 +: 12] = 12'hFFF; mask = 8'h80;
    rx_q = {};
    pulse_tick(1'b1);
    wait_idle("ch7", vcyc);
    lit = {8'hA5, 8'h7F, 8'hFF, 8'h80};
    compare_q("ch7", rx_q, lit);

    // Random frames under random backpressure and changing inputs
    for (int f = 0; f < 8; f++) begin
      rand_data();
      mask = 8'($urandom_range(1, 255));
      exp_q = model_frame(ch_data, mask);
      rx_q = {};
      pulse_tick(1'b1);
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
        @(posedge clk); #1;
        tx_if.tx_ready = 1'($urandom_range(0, 1));
        rand_data();
        if (!busy) found = 1'b1;
      end
      check($sformatf("rnd%0d_done", f), found, 1'b1);
      tx_if.tx_ready = 1'b1;
      compare_q($sformatf("rnd%0d", f), rx_q, exp_q);
    end
    check("rnd_ovr", ovr, 8'd0);

    // Enable dropped mid-frame
    rand_data(); mask = 8'hFF;
    exp_q = model_frame(ch_data, mask);
    rx_q = {};
    pulse_tick(1'b1);
    @(posedge clk); #1;
    enb = 1'b0;
    wait_idle("enb_drop", vcyc);
    enb = 1'b1;
    compare_q("enb_drop", rx_q, exp_q);

    // Asynchronous reset mid-frame
    rand_data(); mask = 8'hFF;
    rx_q = {};
    pulse_tick(1'b1);
    pulse_tick(1'b1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 3) found = 1'b1;
    end
    check("rst_mid_reached", found, 1'b1);
    check("rst_mid_pre_ovr", ovr, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", tx_if.tx_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_data", tx_if.tx_data, 8'h00);
    check("rst_mid_ovr", ovr, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_data(); mask = 8'hFF;
    exp_q = model_frame(ch_data, mask);
    rx_q = {};
    pulse_tick(1'b1);
    wait_idle("post_rst", vcyc);
    check("post_rst_run", vcyc, 18);
    compare_q("post_rst", rx_q, exp_q);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_uart_streamer.md
# adc_uart_streamer

Parametrised bridge between the multi-channel ADC controller readings and the `uart_tx` serialiser. It replaces the single-channel, low-byte-only transfer with full-width, multi-channel framed streaming. On each decimated sample tick it snapshots the enabled channels and emits one framed byte sequence: sync byte, two bytes per enabled channel, then an XOR checksum. Transfers use a valid/ready handshake.

## Interface
Parameters:
- `NUM_CH`, default 8: number of ADC channels, 1..8.
- `SAMPLE_W`, default 12: ADC sample width, 1..12; zero-extended to 12 bits for framing.
- `DATA_BITS`, default 8: UART byte width; fixed at 8, other values unsupported.
- `DECIM`, default 1: emit one frame every `DECIM`-th qualified tick, 1..65535.
- `SYNC_BYTE`, default 8'hA5: frame header value.

Ports:
- `i_clk`, in, 1: system clock (PLL output).
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_ch_data`, in, `NUM_CH*SAMPLE_W`: flattened channel readings; channel k occupies bits `[k*SAMPLE_W +: SAMPLE_W]`.
- `i_sample_tick`, in, 1: single-cycle sample strobe.
- `i_enb`, in, 1: stream enable (level).
- `i_ch_mask`, in, `NUM_CH`: channel enable mask; bit k enables channel k.
- `o_tx_data`, out, `DATA_BITS`: byte to `uart_tx`.
- `o_tx_valid`, out, 1: `o_tx_data` is valid.
- `i_tx_ready`, in, 1: `uart_tx` can accept a byte.
- `o_busy`, out, 1: a frame is in progress (state is not IDLE).
- `o_overrun_cnt`, out, 8: count of launches dropped because busy; saturates at 255.

## Operation
- FSM states: IDLE, SYNC, HI, LO, CSUM.
- **Qualified tick:** `i_sample_tick` with `i_enb` high.
  - Each qualified tick advances the decimation counter 0..DECIM-1.
  - The tick on which the counter equals DECIM-1 is a launch tick; the counter wraps to 0.
  - While `i_enb` is low, the counter is held at 0.
- **Launch tick in IDLE:**
  - `i_ch_data` and `i_ch_mask` are captured into shadow registers.
  - Checksum is cleared and the state goes to SYNC.
  - If the captured mask is all zero, there is no launch: the state stays IDLE and the overrun count is unchanged.
- **Launch tick while not IDLE:** the frame is dropped, `o_overrun_cnt` increments (saturating at 255), and the frame in progress is unaffected. A launch tick on the same cycle as CSUM acceptance counts as an overrun.
- **Frame byte order:**
  - SYNC_BYTE.
  - For each enabled channel in ascending index order:
    - HI = {ch_idx[3:0], sample12[11:8]}
    - LO = sample12[7:0]
  - CSUM = XOR of all HI and LO bytes. SYNC is excluded.
- **Channel selection:** the next enabled channel is chosen by a priority search above the current index, so disabled channels cost no cycles.
  - From SYNC, the FSM goes to HI of the lowest enabled channel.
  - After LO, it goes to HI of the next enabled channel, or to CSUM if none remain.
- **Handshake:** a byte transfers on a cycle with `o_tx_valid && i_tx_ready`.
  - While valid is high and ready is low, `o_tx_data` is held stable.
  - Valid is never withdrawn before transfer except by reset.
- **Enable mid-frame:** dropping `i_enb` mid-frame does not truncate the frame; it completes.
- **Register stability:** shadow registers are frozen for the whole frame, so `i_ch_data` changes mid-frame have no effect.
- **Reset values:** `o_tx_data`=0, `o_tx_valid`=0, `o_busy`=0, `o_overrun_cnt`=0, state IDLE, decimation counter 0, shadow registers and checksum 0.

## Timing
- Outputs are registered.
- Launch tick at cycle T: `o_tx_valid`=1 with SYNC_BYTE and `o_busy`=1 at T+1.
- Transfer at cycle N: the next byte is presented at N+1 with valid held high, so there are no bubbles inside a frame.
- CSUM transfer at cycle N: `o_tx_valid`=0 and `o_busy`=0 at N+1. The earliest next launch is a tick at N+1.
- Frame length = 2 + 2·popcount(mask) bytes.
- Assertion of `i_rst_n` mid-frame clears all outputs immediately (asynchronously). Deassertion is synchronised externally.

## Test plan
- **Basic frame:** NUM_CH=8, DECIM=1, mask=0x05, ch0=0x123, ch2=0xABC, one tick, ready held high. Expected bytes: A5, 01, 23, 2A, BC, B4, with valid continuous for 6 cycles.
- **Backpressure and stability:** same frame, ready low for 10 cycles while byte 0x23 is presented, and ch0 changed to 0x456 mid-frame. Expected: 0x23 held stable, then the remaining bytes unchanged (2A, BC, B4).
- **Overrun:** a second tick during a frame gives `o_overrun_cnt`=1 and an intact frame. 300 busy ticks give a count of 255.
- **Decimation:** DECIM=4 with 8 qualified ticks gives frames only after the 4th and 8th ticks. Ticks with `i_enb`=0 neither count nor launch.
- **Empty mask:** mask=0 with a tick gives no valid, `o_busy`=0 and overrun count 0. Mask=0x80, ch7=0xFFF gives A5, 7F, FF, 80.
- **Reset mid-frame:** `i_rst_n` low during byte 3 gives valid, busy, data and overrun count all 0 with no clock edge. After release, a new tick yields a full, correct frame.
